// File: rtl/packet_receiver.sv
// Receive side of the byte-parallel packet link: splits length/data/parity framing,
// streams data bytes out and reports completion with parity and length status.
module packet_receiver #(
    parameter logic [7:0] EXP_LEN = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] In,
    input  logic       In_valid,
    output logic [7:0] Data_out,
    output logic       Data_valid,
    output logic [7:0] Length,
    output logic       Busy,
    output logic       Done,
    output logic       Parity_err,
    output logic       Len_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        CLOSE  = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [7:0] data_nx, length_nx;
    logic       acc, acc_nx;
    logic       armed, armed_nx;
    logic       dv_nx, busy_nx, done_nx, perr_nx, lerr_nx;

    // Valid/ready-free link: a byte is consumed on every rising edge where In_valid is high.
    // 'armed' stays low after reset until In_valid is seen low, so the tail of a packet
    // interrupted by reset is never mistaken for a length byte.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_nx    = acc;
        armed_nx  = armed | ~In_valid;
        data_nx   = Data_out;
        dv_nx     = 1'b0;
        length_nx = Length;
        busy_nx   = Busy;
        done_nx   = 1'b0;
        perr_nx   = Parity_err;
        lerr_nx   = Len_err;
        unique case (state)
            IDLE: begin
                if (In_valid && armed) begin
                    length_nx = In;
                    busy_nx   = 1'b1;
                    acc_nx    = ^In;
                    cnt_nx    = 8'd0;
                    perr_nx   = 1'b0;
                    lerr_nx   = (EXP_LEN != 8'h00) && (In != EXP_LEN);
                    state_nx  = (In == 8'h00) ? PARITY : DATA;
                end
            end
            DATA: begin
                if (In_valid) begin
                    data_nx = In;
                    dv_nx   = 1'b1;
                    acc_nx  = acc ^ (^In);
                    cnt_nx  = cnt + 8'd1;
                    if (cnt_nx == Length) state_nx = PARITY;
                end else begin
                    done_nx  = 1'b1;
                    lerr_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            PARITY: begin
                if (In_valid) begin
                    perr_nx  = (In != {7'b0, acc});
                    state_nx = CLOSE;
                end else begin
                    done_nx  = 1'b1;
                    lerr_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            CLOSE: begin
                if (In_valid) begin
                    lerr_nx = 1'b1;
                end else begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            acc        <= 1'b0;
            armed      <= 1'b0;
            Data_out   <= 8'd0;
            Data_valid <= 1'b0;
            Length     <= 8'd0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Parity_err <= 1'b0;
            Len_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            acc        <= acc_nx;
            armed      <= armed_nx;
            Data_out   <= data_nx;
            Data_valid <= dv_nx;
            Length     <= length_nx;
            Busy       <= busy_nx;
            Done       <= done_nx;
            Parity_err <= perr_nx;
            Len_err    <= lerr_nx;
        end
    end

endmodule

// File: tb/tb_packet_receiver.sv
// Scoreboard bench for packet_receiver: two instances (EXP_LEN=0 and EXP_LEN=8'h14)
// share one randomized packet stream; a frame-level model fills the expected queues.
module tb_packet_receiver;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] In = 8'h00;
    logic       In_valid = 1'b0;

    logic [7:0] d_out0, len0, d_out1, len1;
    logic       dv0, busy0, done0, perr0, lerr0;
    logic       dv1, busy1, done1, perr1, lerr1;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_d0[$], exp_d1[$];
    logic [9:0] exp_s0[$], exp_s1[$];   // {len_err, parity_err, length}
    logic [7:0] pkt_data[256];

    packet_receiver #(.EXP_LEN(8'h00)) u_dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .In(In), .In_valid(In_valid),
        .Data_out(d_out0), .Data_valid(dv0), .Length(len0), .Busy(busy0),
        .Done(done0), .Parity_err(perr0), .Len_err(lerr0)
    );

    packet_receiver #(.EXP_LEN(8'h14)) u_dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .In(In), .In_valid(In_valid),
        .Data_out(d_out1), .Data_valid(dv1), .Length(len1), .Busy(busy1),
        .Done(done1), .Parity_err(perr1), .Len_err(lerr1)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=strobe expected=none", name);
    endtask

    // Monitor: pops the expected queues whenever a DUT presents a strobe.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (dv0) begin
                if (exp_d0.size() == 0) flag_fail("data0_unexpected");
                else begin
                    check("data0", 32'(d_out0), 32'(exp_d0[0]));
                    void'(exp_d0.pop_front());
                end
            end
            if (dv1) begin
                if (exp_d1.size() == 0) flag_fail("data1_unexpected");
                else begin
                    check("data1", 32'(d_out1), 32'(exp_d1[0]));
                    void'(exp_d1.pop_front());
                end
            end
            if (done0) begin
                if (exp_s0.size() == 0) flag_fail("done0_unexpected");
                else begin
                    check("status0", 32'({lerr0, perr0, len0}), 32'(exp_s0[0]));
                    check("busy0_at_done", 32'(busy0), 32'd0);
                    void'(exp_s0.pop_front());
                end
            end
            if (done1) begin
                if (exp_s1.size() == 0) flag_fail("done1_unexpected");
                else begin
                    check("status1", 32'({lerr1, perr1, len1}), 32'(exp_s1[0]));
                    check("busy1_at_done", 32'(busy1), 32'd0);
                    void'(exp_s1.pop_front());
                end
            end
        end
    end

    task automatic put(input logic [7:0] b, input logic v);
        In = b;
        In_valid = v;
        @(posedge Clk);
        #1;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) pkt_data[i] = 8'($urandom_range(0, 255));
    endtask

    // par_sel: 0 correct parity byte, 1 flipped bit, 2 random value 02..FF.
    // n_data < len or with_par=0 truncates the packet; extra bytes only follow a parity byte.
    task automatic send_pkt(input logic [7:0] len, input int n_data, input bit with_par,
                            input int par_sel, input int extra, input int gap);
        int         ones;
        bit         trunc;
        bit         p_err, l_err0, l_err1;
        logic [7:0] e, pb;
        trunc = (n_data < int'(len)) || !with_par;
        ones = $countones(len);
        for (int i = 0; i < n_data; i++) ones += $countones(pkt_data[i]);
        e = 8'(ones % 2);
        case (par_sel)
            0:       pb = e;
            1:       pb = e ^ 8'h01;
            default: pb = 8'($urandom_range(2, 255));
        endcase
        p_err  = trunc ? 1'b0 : (pb != e);
        l_err0 = trunc || (extra > 0);
        l_err1 = l_err0 || (len != 8'h14);
        exp_s0.push_back({l_err0, p_err, len});
        exp_s1.push_back({l_err1, p_err, len});
        put(len, 1'b1);
        for (int i = 0; i < n_data; i++) begin
            exp_d0.push_back(pkt_data[i]);
            exp_d1.push_back(pkt_data[i]);
            put(pkt_data[i], 1'b1);
        end
        if (!trunc) begin
            put(pb, 1'b1);
            for (int i = 0; i < extra; i++) put(8'($urandom_range(0, 255)), 1'b1);
        end
        for (int i = 0; i < gap; i++) put(8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic reset_mid_packet();
        fill_rand(10);
        put(8'd10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_d0.push_back(pkt_data[i]);
            exp_d1.push_back(pkt_data[i]);
            put(pkt_data[i], 1'b1);
        end
        @(negedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("reset_outputs0", 32'({d_out0, dv0, len0, busy0, done0, perr0, lerr0}), 32'd0);
        check("reset_outputs1", 32'({d_out1, dv1, len1, busy1, done1, perr1, lerr1}), 32'd0);
        check("queues_at_reset", 32'(exp_d0.size() + exp_d1.size()), 32'd0);
        put(pkt_data[4], 1'b1);
        put(pkt_data[5], 1'b1);
        Reset_n = 1'b1;
        // Tail of the interrupted packet must be ignored entirely.
        for (int i = 6; i < 10; i++) put(pkt_data[i], 1'b1);
        put(8'h00, 1'b1);
        put(8'h00, 1'b0);
    endtask

    initial begin
        int         len, n, r, extra;
        bit         wp;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_state0", 32'({d_out0, dv0, len0, busy0, done0, perr0, lerr0}), 32'd0);
        check("reset_state1", 32'({d_out1, dv1, len1, busy1, done1, perr1, lerr1}), 32'd0);
        Reset_n = 1'b1;
        put(8'h00, 1'b0);

        pkt_data[0] = 8'h01; pkt_data[1] = 8'h03; pkt_data[2] = 8'h07;
        send_pkt(8'h03, 3, 1'b1, 0, 0, 1);
        send_pkt(8'h03, 3, 1'b1, 1, 0, 1);
        send_pkt(8'h00, 0, 1'b1, 0, 0, 1);
        send_pkt(8'h00, 0, 1'b1, 1, 0, 1);
        send_pkt(8'h00, 0, 1'b1, 2, 0, 1);
        fill_rand(5);
        send_pkt(8'h05, 2, 1'b1, 0, 0, 1);
        fill_rand(4);
        send_pkt(8'h04, 4, 1'b1, 0, 0, 2);
        send_pkt(8'h04, 4, 1'b0, 0, 0, 1);
        fill_rand(20);
        send_pkt(8'h14, 20, 1'b1, 0, 0, 1);
        fill_rand(2);
        send_pkt(8'h02, 2, 1'b1, 0, 0, 1);
        fill_rand(20);
        send_pkt(8'h14, 20, 1'b1, 0, 2, 1);
        fill_rand(255);
        send_pkt(8'hFF, 255, 1'b1, 0, 0, 1);

        reset_mid_packet();
        fill_rand(6);
        send_pkt(8'h06, 6, 1'b1, 0, 0, 1);
        fill_rand(3);
        send_pkt(8'h03, 3, 1'b1, 2, 0, 1);

        for (int k = 0; k < 40; k++) begin
            len = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 30));
            r = int'($urandom_range(0, 5));
            if (r == 0) begin
                n = int'($urandom_range(0, len));
                wp = 1'b0;
            end else begin
                n = len;
                wp = 1'b1;
            end
            extra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            fill_rand(len);
            send_pkt(8'(len), n, wp, int'($urandom_range(0, 2)), extra,
                     int'($urandom_range(1, 3)));
        end

        repeat (3) put(8'h00, 1'b0);
        check("drain_data0", 32'(exp_d0.size()), 32'd0);
        check("drain_data1", 32'(exp_d1.size()), 32'd0);
        check("drain_status0", 32'(exp_s0.size()), 32'd0);
        check("drain_status1", 32'(exp_s1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
